// File: rtl/daq_pkg.sv
// Shared constants for the DAQ line packer: command bytes, frame layout and FSM states.
// The layout helpers are also the reference for the host-side line decoder.
package daq_pkg;

    localparam logic [7:0] CMD_START_BYTE = 8'hFF;
    localparam logic [7:0] CMD_RESET_BYTE = 8'hC0;
    localparam logic [7:0] CMD_CLOSE_BYTE = 8'hC7;

    localparam logic [7:0] HDR_MARK = 8'hF0;
    localparam logic [7:0] TRL_MARK = 8'hAA;
    localparam logic [7:0] TRL_PAD  = 8'h00;

    localparam int unsigned WORD_W              = 32;
    localparam int unsigned DEF_PAYLOAD_WORDS   = 24;
    localparam int unsigned DEF_LINES_PER_FRAME = 256;
    localparam int unsigned DEF_GAP_CYCLES      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPay,
        StTrl,
        StGap
    } daq_state_e;

    function automatic logic [WORD_W-1:0] hdr_word(input logic [7:0]  frame_lo,
                                                   input logic [15:0] line);
        return {HDR_MARK, frame_lo, line};
    endfunction

    function automatic logic [WORD_W-1:0] pay_word(input logic [15:0] line,
                                                   input logic [15:0] col);
        return {line, col};
    endfunction

    function automatic logic [WORD_W-1:0] trl_word(input logic [15:0] line);
        return {TRL_MARK, TRL_PAD, line};
    endfunction

endpackage

// File: rtl/daq_cmd_decode.sv
// Change-detecting decoder for the level-held DAQ command byte.
// Each command pulses for exactly one cycle when the byte changes to its value.
module daq_cmd_decode
    import daq_pkg::*;
#(
    parameter logic [7:0] CMD_START = CMD_START_BYTE,
    parameter logic [7:0] CMD_RESET = CMD_RESET_BYTE,
    parameter logic [7:0] CMD_CLOSE = CMD_CLOSE_BYTE
) (
    input  logic       bus_clk,
    input  logic       reset_n,
    input  logic [7:0] cfg_byte,
    output logic       start_fire,
    output logic       reset_fire,
    output logic       close_fire
);

    logic [7:0] cfg_prev_q;
    logic       cfg_changed;

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_prev_q <= 8'h00;
        end else begin
            cfg_prev_q <= cfg_byte;
        end
    end

    // Rewriting the same value leaves cfg_changed low, so it never re-fires.
    assign cfg_changed = (cfg_byte != cfg_prev_q);

    always_comb begin
        start_fire = cfg_changed && (cfg_byte == CMD_START);
        reset_fire = cfg_changed && (cfg_byte == CMD_RESET);
        close_fire = cfg_changed && (cfg_byte == CMD_CLOSE);
    end

endmodule

// File: rtl/daq_line_packer.sv
// Framed line generator feeding the 32-bit read FIFO: header, payload words, trailer, gap.
// Paces on fifo_full so every accepted word is written exactly once.
module daq_line_packer
    import daq_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS   = DEF_PAYLOAD_WORDS,
    parameter int unsigned LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int unsigned GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter logic [7:0]  CMD_START       = CMD_START_BYTE,
    parameter logic [7:0]  CMD_RESET       = CMD_RESET_BYTE,
    parameter logic [7:0]  CMD_CLOSE       = CMD_CLOSE_BYTE
) (
    input  logic        bus_clk,
    input  logic        reset_n,
    input  logic [7:0]  cfg_byte,
    input  logic        stream_open,
    input  logic        fifo_full,
    output logic [31:0] fifo_din,
    output logic        fifo_wren,
    output logic        daq_active,
    output logic [15:0] frame_cnt,
    output logic [15:0] line_cnt
);

    localparam logic [15:0] LastCol  = 16'(PAYLOAD_WORDS - 1);
    localparam logic [15:0] LastLine = 16'(LINES_PER_FRAME - 1);
    // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
    localparam logic [31:0] LastGap  = 32'(GAP_CYCLES) - 32'd1;

    daq_state_e  state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] line_q, line_d;
    logic [15:0] frame_q, frame_d;
    logic [31:0] gap_q, gap_d;
    logic        close_pend_q, close_pend_d;

    logic start_fire;
    logic reset_fire;
    logic close_fire;
    logic abort;
    logic in_line;
    logic accept;
    logic close_now;

    daq_cmd_decode #(
        .CMD_START (CMD_START),
        .CMD_RESET (CMD_RESET),
        .CMD_CLOSE (CMD_CLOSE)
    ) u_cmd_decode (
        .bus_clk    (bus_clk),
        .reset_n    (reset_n),
        .cfg_byte   (cfg_byte),
        .start_fire (start_fire),
        .reset_fire (reset_fire),
        .close_fire (close_fire)
    );

    assign abort     = reset_fire || !stream_open;
    assign in_line   = (state_q == StHdr) || (state_q == StPay) || (state_q == StTrl);
    assign accept    = in_line && !fifo_full && !abort;
    // A close arriving in the very cycle the line ends still stops at that line.
    assign close_now = close_pend_q || close_fire;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        line_d       = line_q;
        frame_d      = frame_q;
        gap_d        = gap_q;
        close_pend_d = close_pend_q;

        if (close_fire && (state_q != StIdle)) begin
            close_pend_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start_fire) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (accept) begin
                    state_d = StPay;
                    col_d   = 16'd0;
                end
            end
            StPay: begin
                if (accept) begin
                    col_d = col_q + 16'd1;
                    if (col_q == LastCol) begin
                        state_d = StTrl;
                    end
                end
            end
            StTrl: begin
                if (accept) begin
                    if (line_q == LastLine) begin
                        line_d  = 16'd0;
                        frame_d = frame_q + 16'd1;
                    end else begin
                        line_d = line_q + 16'd1;
                    end
                    gap_d = 32'd0;
                    if (close_now) begin
                        state_d      = StIdle;
                        close_pend_d = 1'b0;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = StHdr;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (close_now) begin
                    state_d      = StIdle;
                    close_pend_d = 1'b0;
                end else if (gap_q == LastGap) begin
                    state_d = StHdr;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a pending close and a start in IDLE.
        if (abort) begin
            state_d      = StIdle;
            col_d        = 16'd0;
            line_d       = 16'd0;
            frame_d      = 16'd0;
            gap_d        = 32'd0;
            close_pend_d = 1'b0;
        end
    end

    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            col_q        <= 16'd0;
            line_q       <= 16'd0;
            frame_q      <= 16'd0;
            gap_q        <= 32'd0;
            close_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_q       <= line_d;
            frame_q      <= frame_d;
            gap_q        <= gap_d;
            close_pend_q <= close_pend_d;
        end
    end

    always_comb begin
        fifo_din = 32'd0;
        case (state_q)
            StHdr:   fifo_din = hdr_word(frame_q[7:0], line_q);
            StPay:   fifo_din = pay_word(line_q, col_q);
            StTrl:   fifo_din = trl_word(line_q);
            default: fifo_din = 32'd0;
        endcase
    end

    assign fifo_wren  = accept;
    assign daq_active = (state_q != StIdle);
    assign frame_cnt  = frame_q;
    assign line_cnt   = line_q;

endmodule

// File: doc/daq_line_packer.md
Name: daq_line_packer

Overview:
- Upstream producer for the 32-bit read stream. Replaces the free-running test counter that currently feeds the fifo_32x512 write side.
- Decodes the DAQ command byte (mem_8 location 0) into start / reset / close.
- Emits framed line packets: header word, PAYLOAD_WORDS payload words, trailer word.
- Paces itself on FIFO full, so no word is ever dropped.

Parameters:
PAYLOAD_WORDS, 24, payload words per line (768 bits); legal 1..65535
LINES_PER_FRAME, 256, lines per frame before frame_cnt increments; legal 1..65536
GAP_CYCLES, 4, idle cycles between consecutive lines; 0 allowed
CMD_START, 8'hFF, command byte: start acquisition
CMD_RESET, 8'hC0, command byte: abort and clear counters
CMD_CLOSE, 8'hC7, command byte: stop after the current line

Ports:
bus_clk  in  1  system clock (Xillybus bus clock)
reset_n  in  1  asynchronous active-low reset
cfg_byte  in  8  command byte, level-held (mem_8 address 0)
stream_open  in  1  user_r_read_32_open; low aborts like CMD_RESET
fifo_full  in  1  FIFO full flag
fifo_din  out  32  FIFO write data
fifo_wren  out  1  FIFO write enable
daq_active  out  1  high while not IDLE (drives GPIO_LED_6)
frame_cnt  out  16  completed frames, wraps at 2^16
line_cnt  out  16  current line index within the frame

Behaviour:
- Reset: all registers clear; state IDLE; fifo_wren=0, fifo_din=0, daq_active=0, frame_cnt=0, line_cnt=0, cfg_prev=8'h00.
- Command detection:
  - cfg_prev<=cfg_byte every cycle.
  - A command fires for one cycle when cfg_byte!=cfg_prev and cfg_byte equals a CMD_* value.
  - Re-writing the same value does not re-fire. Other values are ignored.
- States: IDLE, HDR, PAY, TRL, GAP.
- IDLE: start fire and stream_open=1 -> HDR on the next cycle. Start while stream_open=0 is ignored.
- HDR:
  - Word {8'hF0, frame_cnt[7:0], line_cnt}.
  - On accept -> PAY with col=0.
- PAY:
  - Word {line_cnt, col[15:0]}.
  - On accept, col++.
  - Accept with col==PAYLOAD_WORDS-1 -> TRL.
- TRL:
  - Word {8'hAA, 8'h00, line_cnt}.
  - On accept, line_cnt++.
  - At LINES_PER_FRAME-1: line_cnt<=0 and frame_cnt++.
  - Next state: GAP if GAP_CYCLES>0, else HDR. Go to IDLE instead if close is pending.
- GAP: counts GAP_CYCLES cycles, then -> HDR. Goes to IDLE if close is pending.
- Accept:
  - fifo_wren = (state in HDR/PAY/TRL) && !fifo_full && !abort.
  - Combinational from registered state, so the FIFO sees full and wren in the same cycle.
  - fifo_din is combinational from registered state and counters.
  - Every accepted word is written exactly once.
- Stall: fifo_full=1 holds state, col and din stable; wren=0. Unbounded stall is legal.
- Close:
  - Sets close_pending. Has no effect in IDLE.
  - The current line completes through TRL, then IDLE; close_pending clears.
  - Counters are retained, so a later start continues line/frame numbering.
- Abort:
  - Triggered by a reset fire or stream_open=0, in any state.
  - Next cycle: IDLE; line_cnt, frame_cnt, col, close_pending cleared.
  - fifo_wren is forced 0 in the abort cycle itself; partial lines are not completed.
- Simultaneous events:
  - Abort beats close.
  - Start while running is ignored.
  - Start and a pending close in the same line: the close wins and the start is dropped.
- daq_active = (state!=IDLE), registered from the state.
- Widths: col is 16 bits; line_cnt wraps at LINES_PER_FRAME; frame_cnt wraps at 2^16.

Decomposition:
- Shared package daq_pkg:
  - CMD_* byte constants, HDR_MARK=8'hF0, TRL_MARK=8'hAA.
  - State enum localparams.
  - Frame layout constants, also used by the host-side decoder.
- One natural sub-module: daq_cmd_decode (cfg_prev register, change-detect compare, one-cycle start/reset/close pulses).
- FSM and counters stay in daq_line_packer.

Test Plan:
- Basic line: write FF, open=1, full=0, defaults -> 26 consecutive writes: F000_0000, 0000_0000..0000_0017, AA00_0000; then 4 idle cycles; next header F000_0001.
- Backpressure: hold fifo_full high for 10 cycles mid-PAY at col=5 -> no wren for those 10 cycles, din stable at 0000_0005; resumes with 0000_0005 once, no gap or duplicate.
- Frame wrap: LINES_PER_FRAME=2, run 3 lines -> headers F000_0000, F000_0001, F001_0000; frame_cnt=1 after line 2.
- Close mid-line: write C7 at PAY col=10 -> line completes through AA00_xxxx, then IDLE, daq_active=0; later FF resumes at the next line_cnt.
- Abort: write C0, or drop stream_open, at PAY col=3 -> wren=0 that cycle, IDLE next, counters 0; a following FF restarts with header F000_0000.
- Command edges: write FF twice while running, plus write 0x55 -> no effect; reset_n asserted mid-PAY -> all outputs 0 asynchronously.
